// File: rtl/nxs_nonce_reporter.sv
// Nonce reporter: queues good nonces from the hash core and serializes each one as a
// 9-byte frame (header + 8 nonce bytes, LSB first) on a valid/ready byte stream.
module nxs_nonce_reporter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          GoodNonceFound,
    input  logic [63:0]                   NonceIn,
    input  logic                          WorkReload,
    output logic [7:0]                    TxByte,
    output logic                          TxValid,
    input  logic                          TxReady,
    output logic [$clog2(FIFO_DEPTH):0]   Pending,
    output logic [15:0]                   DropCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_r;
    logic [63:0]     fifoMem_r [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_r;
    logic [AW-1:0]   rdPtr_r;
    logic [CW-1:0]   count_r;
    logic [63:0]     shiftReg_r;
    logic [3:0]      byteIdx_r;
    logic [7:0]      txByte_r;
    logic            txValid_r;
    logic [15:0]     dropCount_r;

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            drop_s;
    logic            xfer_s;
    logic            lastXfer_s;
    logic            pop_s;
    logic [63:0]     headNonce_s;

    // Queue status and push/pop decisions; fullness uses the pre-edge count only.
    always_comb begin
        full_s      = (count_r == CW'(FIFO_DEPTH));
        empty_s     = (count_r == {CW{1'b0}});
        push_s      = GoodNonceFound & ~WorkReload & ~full_s;
        drop_s      = GoodNonceFound & ~WorkReload & full_s;
        xfer_s      = txValid_r & TxReady;
        lastXfer_s  = (state_r == SEND) & xfer_s & (byteIdx_r == 4'd8);
        headNonce_s = fifoMem_r[rdPtr_r];
        case (state_r)
            IDLE:    pop_s = ~empty_s & ~WorkReload;
            SEND:    pop_s = ~empty_s & ~WorkReload & lastXfer_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Nonce storage; contents need no reset because pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifoMem_r[wrPtr_r] <= NonceIn;
        end
    end

    // Queue pointers and occupancy; a reload discards everything still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (WorkReload) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + AW'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of nonces lost to a full queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropCount_r <= 16'h0000;
        end else if (drop_s && (dropCount_r != 16'hFFFF)) begin
            dropCount_r <= dropCount_r + 16'h0001;
        end else begin
            dropCount_r <= dropCount_r;
        end
    end

    // Frame serializer: header then nonce bytes LSB first, chaining frames back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shiftReg_r <= 64'h0;
            byteIdx_r  <= 4'd0;
            txByte_r   <= 8'h00;
            txValid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shiftReg_r <= headNonce_s;
                        txByte_r   <= HDR_BYTE;
                        txValid_r  <= 1'b1;
                        byteIdx_r  <= 4'd0;
                        state_r    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer_s) begin
                        if (byteIdx_r == 4'd8) begin
                            if (pop_s) begin
                                shiftReg_r <= headNonce_s;
                                txByte_r   <= HDR_BYTE;
                                byteIdx_r  <= 4'd0;
                            end else begin
                                txValid_r  <= 1'b0;
                                state_r    <= IDLE;
                            end
                        end else begin
                            txByte_r   <= shiftReg_r[7:0];
                            shiftReg_r <= {8'h00, shiftReg_r[63:8]};
                            byteIdx_r  <= byteIdx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    txValid_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign TxByte    = txByte_r;
    assign TxValid   = txValid_r;
    assign Pending   = count_r;
    assign DropCount = dropCount_r;

endmodule

// File: tb/tb_nxs_nonce_reporter.sv
// Self-checking bench for nxs_nonce_reporter: expected frame bytes are queued as nonces
// are driven and compared byte-by-byte as the DUT transfers them.
module tb_nxs_nonce_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic        GoodNonceFound;
    logic [63:0] NonceIn;
    logic        WorkReload;
    logic [7:0]  TxByte;
    logic        TxValid;
    logic        TxReady;
    logic [2:0]  Pending;
    logic [15:0] DropCount;

    int          errCnt = 0;
    int          chkCnt = 0;
    logic [7:0]  sbQ [$];
    logic        holdValid = 1'b0;
    logic [7:0]  heldByte = 8'h00;

    nxs_nonce_reporter #(.FIFO_DEPTH(4), .HDR_BYTE(8'hA5)) dut (
        .clk            (clk),
        .rst            (rst),
        .GoodNonceFound (GoodNonceFound),
        .NonceIn        (NonceIn),
        .WorkReload     (WorkReload),
        .TxByte         (TxByte),
        .TxValid        (TxValid),
        .TxReady        (TxReady),
        .Pending        (Pending),
        .DropCount      (DropCount)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectFrame(input logic [63:0] n);
        sbQ.push_back(8'hA5);
        for (int k = 0; k < 8; k++) sbQ.push_back(n[8*k +: 8]);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int t;
        t = 0;
        while ((sbQ.size() != 0 || TxValid) && t < budget) begin
            tick();
            t++;
        end
        checkVal({tag, "_sb_left"}, 64'(sbQ.size()), 64'd0);
        checkVal({tag, "_txvalid"}, 64'(TxValid), 64'd0);
    endtask

    // Byte monitor: compare each transfer to the scoreboard and check hold under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid) checkVal("hold", 64'(TxByte), 64'(heldByte));
            if (TxValid && TxReady) begin
                if (sbQ.size() == 0) checkVal("sb_extra", 64'(sbQ.size()), 64'd1);
                else checkVal("byte", 64'(TxByte), 64'(sbQ.pop_front()));
            end
            holdValid = TxValid && !TxReady;
            heldByte  = TxByte;
        end
    end

    initial begin
        int len;
        rst = 1'b1; GoodNonceFound = 1'b0; NonceIn = 64'h0; WorkReload = 1'b0; TxReady = 1'b1;
        repeat (3) tick();
        checkVal("rst_txvalid", 64'(TxValid), 64'd0);
        checkVal("rst_txbyte", 64'(TxByte), 64'd0);
        checkVal("rst_pending", 64'(Pending), 64'd0);
        checkVal("rst_drop", 64'(DropCount), 64'd0);
        rst = 1'b0;
        tick();

        // Single nonce, TxReady high.
        GoodNonceFound = 1'b1; NonceIn = 64'h0123456789ABCDEF; expectFrame(NonceIn);
        tick();
        GoodNonceFound = 1'b0;
        checkVal("single_pend1", 64'(Pending), 64'd1);
        checkVal("single_txv_n1", 64'(TxValid), 64'd0);
        tick();
        checkVal("single_txv_n2", 64'(TxValid), 64'd1);
        checkVal("single_hdr", 64'(TxByte), 64'hA5);
        checkVal("single_pend0", 64'(Pending), 64'd0);
        len = 0;
        while (TxValid && len < 100) begin len++; tick(); end
        checkVal("single_len", 64'(len), 64'd9);
        waitDrain("single", 20);

        // Backpressure: TxReady toggles every cycle.
        GoodNonceFound = 1'b1; NonceIn = 64'h0123456789ABCDEF; expectFrame(NonceIn);
        tick();
        GoodNonceFound = 1'b0;
        tick();
        len = 0;
        while (TxValid && len < 100) begin
            TxReady = (len % 2 == 0);
            len++;
            tick();
        end
        checkVal("bp_len", 64'(len), 64'd17);
        TxReady = 1'b1;
        waitDrain("bp", 20);

        // Overflow: six strobes with the link stalled.
        TxReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            GoodNonceFound = 1'b1;
            NonceIn = 64'hF0E1D2C3B4A59687 + 64'(i) * 64'h0101010101010101;
            if (i < 5) expectFrame(NonceIn);
            tick();
        end
        GoodNonceFound = 1'b0;
        checkVal("ovf_pending", 64'(Pending), 64'd4);
        checkVal("ovf_drop", 64'(DropCount), 64'd1);
        checkVal("ovf_txvalid", 64'(TxValid), 64'd1);
        checkVal("ovf_hdr", 64'(TxByte), 64'hA5);
        TxReady = 1'b1;
        len = 0;
        while (TxValid && len < 200) begin len++; tick(); end
        checkVal("ovf_len", 64'(len), 64'd45);
        waitDrain("ovf", 20);

        // Reload during byte 3 of a frame with two queued.
        for (int i = 0; i < 3; i++) begin
            GoodNonceFound = 1'b1;
            NonceIn = 64'h1122334455667788 ^ (64'(i) << 60);
            if (i == 0) expectFrame(NonceIn);
            tick();
        end
        GoodNonceFound = 1'b0;
        tick();
        tick();
        checkVal("rld_pend_before", 64'(Pending), 64'd2);
        WorkReload = 1'b1;
        tick();
        WorkReload = 1'b0;
        checkVal("rld_pend_after", 64'(Pending), 64'd0);
        checkVal("rld_txvalid", 64'(TxValid), 64'd1);
        waitDrain("rld", 30);
        repeat (5) tick();
        checkVal("rld_quiet", 64'(TxValid), 64'd0);

        // Strobe together with reload is discarded.
        GoodNonceFound = 1'b1; WorkReload = 1'b1; NonceIn = 64'hBADBADBADBADBAD0;
        tick();
        GoodNonceFound = 1'b0; WorkReload = 1'b0;
        checkVal("sim_pending", 64'(Pending), 64'd0);
        tick();
        checkVal("sim_txvalid", 64'(TxValid), 64'd0);
        checkVal("sim_drop", 64'(DropCount), 64'd1);

        // Strobe while full in the same cycle as the pop: still dropped.
        TxReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            GoodNonceFound = 1'b1;
            NonceIn = 64'h0F1E2D3C4B5A6978 + 64'(i);
            expectFrame(NonceIn);
            tick();
        end
        GoodNonceFound = 1'b0;
        checkVal("fp_pending_full", 64'(Pending), 64'd4);
        TxReady = 1'b1;
        repeat (8) tick();
        GoodNonceFound = 1'b1; NonceIn = 64'hDEADBEEFDEADBEEF;
        tick();
        GoodNonceFound = 1'b0;
        checkVal("fp_pending", 64'(Pending), 64'd3);
        checkVal("fp_drop", 64'(DropCount), 64'd2);
        waitDrain("fp", 100);

        // Saturate the drop counter, then reset mid-frame.
        TxReady = 1'b0;
        for (int i = 0; i < 5 + 65537; i++) begin
            GoodNonceFound = 1'b1;
            NonceIn = 64'hA0A1A2A3A4A5A6A7 + 64'(i);
            if (i < 5) expectFrame(NonceIn);
            if (i == 105) checkVal("sat_midcount", 64'(DropCount), 64'd102);
            tick();
        end
        GoodNonceFound = 1'b0;
        checkVal("sat_drop", 64'(DropCount), 64'hFFFF);
        checkVal("sat_pending", 64'(Pending), 64'd4);
        TxReady = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkVal("mrst_txvalid", 64'(TxValid), 64'd0);
        checkVal("mrst_pending", 64'(Pending), 64'd0);
        checkVal("mrst_drop", 64'(DropCount), 64'd0);
        sbQ.delete();
        rst = 1'b0;
        repeat (4) tick();
        checkVal("mrst_quiet", 64'(TxValid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
